// File: rtl/nv_nvdla_cdma_csb_reg_bridge_pkg.sv
// Shared definitions for the CDMA CSB register bridge.
// Holds the bridge FSM state type, the default page decode constants,
// and the CSB field widths used by the bridge and its decode sub-module.
package nv_nvdla_cdma_csb_reg_bridge_pkg;

  localparam int unsigned CSB_ADDR_W = 22;
  localparam int unsigned CSB_DATA_W = 32;
  localparam int unsigned REG_OFS_W  = 12;
  localparam int unsigned BLK_W      = 12;

  // Byte-address bits [23:12] selecting the CDMA page (0x5000).
  localparam logic [BLK_W-1:0]     BLK_BASE_DEF   = 12'h005;
  // Highest byte offset owned by the single register group.
  localparam logic [REG_OFS_W-1:0] SINGLE_TOP_DEF = 12'h00c;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/nv_nvdla_cdma_csb_reg_decode.sv
// Register-group select for the CDMA CSB bridge.
// Offsets 0..SINGLE_TOP belong to the single group; higher offsets go to
// the dual group picked by producer (0 = d0, 1 = d1).
// Ports:
//   reg_offset      byte offset within the page
//   producer        dual-group pointer
//   wr_req          qualified write request (hit, write, ACCESS cycle)
//   s/d0/d1_rd      read data from each group
//   s/d0/d1_wr_en   one-hot write strobes
//   rd_data         read data of the selected group
module nv_nvdla_cdma_csb_reg_decode
  import nv_nvdla_cdma_csb_reg_bridge_pkg::*;
#(
  parameter logic [REG_OFS_W-1:0] SINGLE_TOP = SINGLE_TOP_DEF
) (
  input  logic [REG_OFS_W-1:0]  reg_offset,
  input  logic                  producer,
  input  logic                  wr_req,
  input  logic [CSB_DATA_W-1:0] s_rd,
  input  logic [CSB_DATA_W-1:0] d0_rd,
  input  logic [CSB_DATA_W-1:0] d1_rd,
  output logic                  s_wr_en,
  output logic                  d0_wr_en,
  output logic                  d1_wr_en,
  output logic [CSB_DATA_W-1:0] rd_data
);

  logic sel_single;

  always_comb begin
    sel_single = (reg_offset <= SINGLE_TOP);
    s_wr_en    = wr_req &  sel_single;
    d0_wr_en   = wr_req & !sel_single & !producer;
    d1_wr_en   = wr_req & !sel_single &  producer;
    if (sel_single) begin
      rd_data = s_rd;
    end else if (producer) begin
      rd_data = d1_rd;
    end else begin
      rd_data = d0_rd;
    end
  end

endmodule

// File: rtl/nv_nvdla_cdma_csb_reg_bridge.sv
// CSB front end of the CDMA register space.
// Accepts one CSB request at a time, decodes the CDMA page hit, drives the
// single/dual register groups for one ACCESS cycle and returns a response
// for reads and non-posted writes.
// Ports:
//   nvdla_core_clk / nvdla_core_rst     clock, synchronous active-high reset
//   csb_req_*                           request channel (ready only in IDLE)
//   csb_rsp_*                           response channel (held until accepted)
//   reg_offset, reg_wr_data             shared register-group address/data
//   s/d0/d1_reg_wr_en                   per-group write strobes
//   s/d0/d1_reg_rd_data                 per-group combinational read data
//   producer                            dual-group pointer, sampled in ACCESS
module nv_nvdla_cdma_csb_reg_bridge
  import nv_nvdla_cdma_csb_reg_bridge_pkg::*;
#(
  parameter logic [BLK_W-1:0]     BLK_BASE   = BLK_BASE_DEF,
  parameter logic [REG_OFS_W-1:0] SINGLE_TOP = SINGLE_TOP_DEF
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  csb_req_valid,
  output logic                  csb_req_ready,
  input  logic [CSB_ADDR_W-1:0] csb_req_addr,
  input  logic [CSB_DATA_W-1:0] csb_req_wdat,
  input  logic                  csb_req_write,
  input  logic                  csb_req_nposted,
  output logic                  csb_rsp_valid,
  input  logic                  csb_rsp_ready,
  output logic [CSB_DATA_W-1:0] csb_rsp_rdat,
  output logic                  csb_rsp_is_write,
  output logic                  csb_rsp_error,
  output logic [REG_OFS_W-1:0]  reg_offset,
  output logic [CSB_DATA_W-1:0] reg_wr_data,
  output logic                  s_reg_wr_en,
  output logic                  d0_reg_wr_en,
  output logic                  d1_reg_wr_en,
  input  logic [CSB_DATA_W-1:0] s_reg_rd_data,
  input  logic [CSB_DATA_W-1:0] d0_reg_rd_data,
  input  logic [CSB_DATA_W-1:0] d1_reg_rd_data,
  input  logic                  producer
);

  bridge_state_e         state, state_nxt;
  logic                  req_accept;
  logic                  write_q;
  logic                  nposted_q;
  logic                  hit_q;
  logic                  wr_req;
  logic [CSB_DATA_W-1:0] dec_rd_data;

  always_comb begin
    csb_req_ready = (state == IDLE) & !nvdla_core_rst;
    req_accept    = csb_req_valid & csb_req_ready;
    csb_rsp_valid = (state == RESP);
    // Strobes are gated by reset so a reset landing in ACCESS never writes.
    wr_req        = (state == ACCESS) & hit_q & write_q & !nvdla_core_rst;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = (!write_q || nposted_q) ? RESP : IDLE;
      RESP:    if (csb_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state            <= IDLE;
      reg_offset       <= '0;
      reg_wr_data      <= '0;
      write_q          <= 1'b0;
      nposted_q        <= 1'b0;
      hit_q            <= 1'b0;
      csb_rsp_rdat     <= '0;
      csb_rsp_is_write <= 1'b0;
      csb_rsp_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_accept) begin
        reg_offset  <= {csb_req_addr[9:0], 2'b00};
        reg_wr_data <= csb_req_wdat;
        write_q     <= csb_req_write;
        nposted_q   <= csb_req_nposted;
        hit_q       <= (csb_req_addr[21:10] == BLK_BASE);
      end
      // Response fields are frozen at the end of ACCESS, so producer or
      // rd_data changes during RESP cannot disturb the held response.
      if (state == ACCESS) begin
        csb_rsp_rdat     <= (hit_q && !write_q) ? dec_rd_data : '0;
        csb_rsp_is_write <= write_q;
        csb_rsp_error    <= !hit_q;
      end
    end
  end

  nv_nvdla_cdma_csb_reg_decode #(
    .SINGLE_TOP (SINGLE_TOP)
  ) u_decode (
    .reg_offset (reg_offset),
    .producer   (producer),
    .wr_req     (wr_req),
    .s_rd       (s_reg_rd_data),
    .d0_rd      (d0_reg_rd_data),
    .d1_rd      (d1_reg_rd_data),
    .s_wr_en    (s_reg_wr_en),
    .d0_wr_en   (d0_reg_wr_en),
    .d1_wr_en   (d1_reg_wr_en),
    .rd_data    (dec_rd_data)
  );

endmodule

// File: tb/tb_nv_nvdla_cdma_csb_reg_bridge.sv
// Directed self-checking bench for the CDMA CSB register bridge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nv_nvdla_cdma_csb_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [21:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic        req_nposted;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdat;
  logic        rsp_is_write;
  logic        rsp_error;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        s_wr_en, d0_wr_en, d1_wr_en;
  logic [31:0] s_rd, d0_rd, d1_rd;
  logic        producer;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  nv_nvdla_cdma_csb_reg_bridge #(
    .BLK_BASE   (12'h005),
    .SINGLE_TOP (12'h00c)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .csb_req_valid    (req_valid),
    .csb_req_ready    (req_ready),
    .csb_req_addr     (req_addr),
    .csb_req_wdat     (req_wdat),
    .csb_req_write    (req_write),
    .csb_req_nposted  (req_nposted),
    .csb_rsp_valid    (rsp_valid),
    .csb_rsp_ready    (rsp_ready),
    .csb_rsp_rdat     (rsp_rdat),
    .csb_rsp_is_write (rsp_is_write),
    .csb_rsp_error    (rsp_error),
    .reg_offset       (reg_offset),
    .reg_wr_data      (reg_wr_data),
    .s_reg_wr_en      (s_wr_en),
    .d0_reg_wr_en     (d0_wr_en),
    .d1_reg_wr_en     (d1_wr_en),
    .s_reg_rd_data    (s_rd),
    .d0_reg_rd_data   (d0_rd),
    .d1_reg_rd_data   (d1_rd),
    .producer         (producer)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // {s,d0,d1} strobes packed for compact checks
  function automatic logic [31:0] wen();
    return 32'({s_wr_en, d0_wr_en, d1_wr_en});
  endfunction

  task automatic put_req(input logic [21:0] a, input logic [31:0] d,
                         input logic w, input logic np);
    req_valid   = 1'b1;
    req_addr    = a;
    req_wdat    = d;
    req_write   = w;
    req_nposted = np;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdat = '0;
    req_write = 1'b0; req_nposted = 1'b0; rsp_ready = 1'b1;
    s_rd = 32'h0003000f; d0_rd = 32'hd0d0_0001; d1_rd = 32'hd1d1_0002;
    producer = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdat", rsp_rdat, 32'd0);
    chk("rst_iswr_err", 32'({rsp_is_write, rsp_error}), 32'd0);
    chk("rst_offset", 32'(reg_offset), 32'd0);
    chk("rst_wdata", reg_wr_data, 32'd0);
    chk("rst_wen", wen(), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Read 0x5008 from single group, rsp_ready high
    put_req(22'h001402, 32'h0, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    chk("rd1_access_wen", wen(), 32'd0);
    chk("rd1_access_ready", 32'(req_ready), 32'd0);
    chk("rd1_offset", 32'(reg_offset), 32'h008);
    chk("rd1_access_rspv", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd1_rspv", 32'(rsp_valid), 32'd1);
    chk("rd1_rdat", rsp_rdat, 32'h0003000f);
    chk("rd1_err_iswr", 32'({rsp_error, rsp_is_write}), 32'd0);
    chk("rd1_wen", wen(), 32'd0);
    tick();
    chk("rd1_after_rspv", 32'(rsp_valid), 32'd0);
    chk("rd1_after_ready", 32'(req_ready), 32'd1);

    // Posted write 0x5004 wdat=1
    put_req(22'h001401, 32'd1, 1'b1, 1'b0);
    tick(); req_valid = 1'b0;
    chk("pw_wen", wen(), 32'b100);
    chk("pw_offset", 32'(reg_offset), 32'h004);
    chk("pw_wdata", reg_wr_data, 32'd1);
    tick();
    chk("pw_wen_off", wen(), 32'd0);
    chk("pw_rspv", 32'(rsp_valid), 32'd0);
    chk("pw_ready", 32'(req_ready), 32'd1);

    // Boundary: posted write at SINGLE_TOP (0x00c) stays in single group
    producer = 1'b1;
    put_req(22'h001403, 32'h55, 1'b1, 1'b0);
    tick(); req_valid = 1'b0;
    chk("top_wen", wen(), 32'b100);
    tick();

    // Non-posted write to dual offset 0x010, producer=1
    put_req(22'h001404, 32'hcafe, 1'b1, 1'b1);
    tick(); req_valid = 1'b0;
    chk("npw_wen", wen(), 32'b001);
    chk("npw_offset", 32'(reg_offset), 32'h010);
    tick();
    chk("npw_wen_off", wen(), 32'd0);
    chk("npw_rspv", 32'(rsp_valid), 32'd1);
    chk("npw_iswr", 32'(rsp_is_write), 32'd1);
    chk("npw_rdat", rsp_rdat, 32'd0);
    chk("npw_err", 32'(rsp_error), 32'd0);
    tick();
    chk("npw_after_rspv", 32'(rsp_valid), 32'd0);

    // Read 0x6000 misses the CDMA page
    put_req(22'h001800, 32'h0, 1'b0, 1'b0);
    tick(); req_valid = 1'b0;
    chk("miss_wen", wen(), 32'd0);
    tick();
    chk("miss_rspv", 32'(rsp_valid), 32'd1);
    chk("miss_rdat", rsp_rdat, 32'd0);
    chk("miss_err", 32'(rsp_error), 32'd1);
    tick();

    // Missing posted write produces no strobe
    put_req(22'h001801, 32'h77, 1'b1, 1'b0);
    tick(); req_valid = 1'b0;
    chk("missw_wen", wen(), 32'd0);
    tick();
    chk("missw_rspv", 32'(rsp_valid), 32'd0);

    // Dual read (0x020, producer=0) with rsp_ready low for 5 cycles and a
    // posted write queued behind it; producer flips while in RESP.
    producer = 1'b0;
    rsp_ready = 1'b0;
    put_req(22'h001408, 32'h0, 1'b0, 1'b0);
    tick();
    chk("bp_access_wen", wen(), 32'd0);
    put_req(22'h001401, 32'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rspv", 32'(rsp_valid), 32'd1);
      chk("bp_rdat", rsp_rdat, 32'hd0d0_0001);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_wen", wen(), 32'd0);
      if (i == 1) producer = 1'b1;
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_rspv", 32'(rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(req_ready), 32'd1);
    tick(); req_valid = 1'b0;
    chk("bp_pend_wen", wen(), 32'b100);
    chk("bp_pend_wdata", reg_wr_data, 32'd2);
    tick();
    chk("bp_pend_done_ready", 32'(req_ready), 32'd1);

    // Reset during ACCESS of a non-posted write drops it silently
    put_req(22'h001401, 32'h99, 1'b1, 1'b1);
    tick();
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rstacc_wen_gated", wen(), 32'd0);
    tick();
    chk("rstacc_ready", 32'(req_ready), 32'd0);
    chk("rstacc_rspv", 32'(rsp_valid), 32'd0);
    chk("rstacc_offset", 32'(reg_offset), 32'd0);
    chk("rstacc_wdata", reg_wr_data, 32'd0);
    chk("rstacc_rsp_fields", 32'({rsp_is_write, rsp_error}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstacc_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rstacc_idle_ready", 32'(req_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
